// File: rtl/reduce_arbiter_pkg.sv
// Shared types and defaults for the reduce_arbiter slice.
// Holds the tag type, default FIFO depth and a tag-width helper.
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 8
`endif
`ifndef INTEGER_WIDTH
`define INTEGER_WIDTH 8
`endif

package reduce_arbiter_pkg;

  localparam int DEF_NUM_REQ   = 2;
  localparam int DEF_TAG_DEPTH = 8;

  typedef logic [$clog2(DEF_NUM_REQ)-1:0] tag_t;

  // Tag width that stays legal for a single requester.
  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// In-flight tag FIFO: push/pop/full/empty plus registered occupancy.
// Ports: clk, rst, push, pop, din, dout (head), full, empty, count.
module tag_fifo
  import reduce_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_TAG_DEPTH,
  parameter int WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;

  assign dout  = mem[rp];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= din;
    end
  end

  // Pointers are AW bits wide, so they wrap for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reduce_arbiter.sv
// Round-robin front end sharing one tree_reduce among NUM_REQ users.
// Ports: req_* (requests in), tree_* (tree side), rsp_* (responses),
// inflight_cnt (tags outstanding). Macro REDUCE_ARB_PRIO_EN gives
// requester 0 fixed priority over the round-robin group.
module reduce_arbiter
  import reduce_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int LEN       = `MAX_EMBEDDING_DIM,
  parameter int W_IN      = 2 * `INTEGER_WIDTH,
  parameter int W_OUT     = W_IN + $clog2(LEN),
  parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_REQ-1:0]                         req_vld,
  output logic [NUM_REQ-1:0]                         req_rdy,
  input  logic signed [NUM_REQ-1:0][LEN-1:0][W_IN-1:0] req_list,
  output logic                                       tree_vld_in,
  input  logic                                       tree_rdy_out,
  output logic [LEN-1:0][W_IN-1:0]                   tree_list_in,
  input  logic                                       tree_vld_out,
  output logic                                       tree_rdy_in,
  input  logic signed [W_OUT-1:0]                    tree_sum,
  output logic [NUM_REQ-1:0]                         rsp_vld,
  input  logic [NUM_REQ-1:0]                         rsp_rdy,
  output logic signed [W_OUT-1:0]                    rsp_sum,
  output logic [$clog2(TAG_DEPTH):0]                 inflight_cnt
);

  localparam int TW = tag_w(NUM_REQ);

  logic [TW-1:0] rr_ptr;
  logic [TW-1:0] grant;
  logic [TW-1:0] sel;
  logic [TW-1:0] head;
  logic          any;
  logic          full;
  logic          empty;
  logic          ok;
  logic          live;
  logic          issue;
  logic          resp;
  logic          hold_rr;
  int            idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    sel   = '0;
`ifdef REDUCE_ARB_PRIO_EN
    if (req_vld[0]) begin
      any = 1'b1;
    end
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      sel = TW'(idx);
`ifdef REDUCE_ARB_PRIO_EN
      if (!any && sel != '0 && req_vld[sel]) begin
`else
      if (!any && req_vld[sel]) begin
`endif
        grant = sel;
        any   = 1'b1;
      end
    end
  end

`ifdef REDUCE_ARB_PRIO_EN
  assign hold_rr = (grant == '0);
`else
  assign hold_rr = 1'b0;
`endif

  // Reset also gates the handshakes so nothing leaks while flushing.
  assign ok           = !full && !rst;
  assign tree_vld_in  = any && ok;
  assign issue        = tree_vld_in && tree_rdy_out;
  assign tree_list_in = req_list[grant];

  always_comb begin
    req_rdy = '0;
    if (issue) begin
      req_rdy[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (issue && !hold_rr) begin
      rr_ptr <= (grant == TW'(NUM_REQ-1)) ? '0 : grant + 1'b1;
    end
  end

  assign live        = !empty && !rst;
  assign tree_rdy_in = live && rsp_rdy[head];
  assign resp        = tree_vld_out && tree_rdy_in;
  assign rsp_sum     = tree_sum;

  always_comb begin
    rsp_vld = '0;
    if (live && tree_vld_out) begin
      rsp_vld[head] = 1'b1;
    end
  end

  tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (TW)
  ) u_tags (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .pop   (resp),
    .din   (grant),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (inflight_cnt)
  );

endmodule

// File: tb/tb_reduce_arbiter.sv
// Bench for reduce_arbiter with an elastic tree model attached.
// Directed scenarios plus random traffic against a scoreboard.
module tb_reduce_arbiter;

  localparam int N     = 3;
  localparam int LEN   = 8;
  localparam int W_IN  = 16;
  localparam int W_OUT = 19;
  localparam int TD    = 8;
  localparam int TQ    = 16;
  localparam int LAT   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_vld = '0;
  logic [N-1:0] rsp_rdy = '0;
  logic [N-1:0] req_rdy;
  logic [N-1:0] rsp_vld;
  logic signed [N-1:0][LEN-1:0][W_IN-1:0] req_list = '0;
  logic tree_vld_in, tree_rdy_out, tree_vld_out, tree_rdy_in;
  logic [LEN-1:0][W_IN-1:0] tree_list_in;
  logic signed [W_OUT-1:0] tree_sum, rsp_sum;
  logic [$clog2(TD):0] inflight_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reduce_arbiter #(
    .NUM_REQ(N), .LEN(LEN), .W_IN(W_IN),
    .W_OUT(W_OUT), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_list(req_list),
    .tree_vld_in(tree_vld_in),
    .tree_rdy_out(tree_rdy_out),
    .tree_list_in(tree_list_in),
    .tree_vld_out(tree_vld_out),
    .tree_rdy_in(tree_rdy_in),
    .tree_sum(tree_sum),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .rsp_sum(rsp_sum),
    .inflight_cnt(inflight_cnt)
  );

  function automatic logic signed [W_OUT-1:0] vsum(
    input logic [LEN-1:0][W_IN-1:0] l);
    logic signed [W_OUT-1:0] s;
    s = '0;
    for (int j = 0; j < LEN; j++) begin
      s = s + W_OUT'($signed(l[j]));
    end
    return s;
  endfunction

  // Elastic tree: fixed latency, deep enough never to throttle.
  logic signed [W_OUT-1:0] tq_sum [TQ];
  int tq_due [TQ];
  int tq_rp = 0;
  int tq_wp = 0;
  int tq_n  = 0;
  int cyc   = 0;
  logic tm_push, tm_pop;

  assign tree_rdy_out = (tq_n < TQ);
  assign tree_vld_out = (tq_n > 0) && (cyc >= tq_due[tq_rp]);
  assign tree_sum     = tq_sum[tq_rp];
  assign tm_push      = tree_vld_in && tree_rdy_out;
  assign tm_pop       = tree_vld_out && tree_rdy_in;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      tq_rp <= 0;
      tq_wp <= 0;
      tq_n  <= 0;
    end else begin
      if (tm_push) begin
        tq_sum[tq_wp] <= vsum(tree_list_in);
        tq_due[tq_wp] <= cyc + LAT;
        tq_wp <= (tq_wp + 1) % TQ;
      end
      if (tm_pop) begin
        tq_rp <= (tq_rp + 1) % TQ;
      end
      tq_n <= tq_n + int'(tm_push) - int'(tm_pop);
    end
  end

  typedef struct {
    int tag;
    logic signed [W_OUT-1:0] sum;
  } ent_t;

  ent_t sb[$];
  int m_rr = 0;
  int fill = 0;
  int last_g;
  int last_cnt;
  logic [N-1:0] last_rsp;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v,
                              input int rr);
    int i;
`ifdef REDUCE_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      i = (rr + k) % N;
`ifdef REDUCE_ARB_PRIO_EN
      if (i != 0 && v[i]) return i;
`else
      if (v[i]) return i;
`endif
    end
    return -1;
  endfunction

  task automatic step(input logic [N-1:0] v,
                      input logic [N-1:0] rr,
                      input logic r);
    int g, h;
    logic ok, live, evi, hs;
    logic [N-1:0] er, ev;
    @(negedge clk);
    rst = r;
    req_vld = v;
    rsp_rdy = rr;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < LEN; j++) begin
        case (fill)
          1:       req_list[i][j] = 16'h0001;
          2:       req_list[i][j] = 16'hFFFE;
          default: req_list[i][j] = 16'($urandom);
        endcase
      end
    end
    #1;
    g    = pick(v, m_rr);
    ok   = !r && (sb.size() < TD);
    evi  = ok && (g >= 0);
    er   = '0;
    if (evi && tree_rdy_out) er[g] = 1'b1;
    live = !r && (sb.size() > 0);
    h    = live ? sb[0].tag : 0;
    ev   = '0;
    if (live && tree_vld_out) ev[h] = 1'b1;
    hs   = live && tree_vld_out && rr[h];
    chk("req_rdy", req_rdy, er);
    chk("tree_vld_in", tree_vld_in, evi);
    chk("rsp_vld", rsp_vld, ev);
    chk("tree_rdy_in", tree_rdy_in, live && rr[h]);
    chk("inflight", inflight_cnt, sb.size());
    if (evi) chk("tree_list", tree_list_in, req_list[g]);
    if (hs) chk("rsp_sum", rsp_sum, sb[0].sum);
    last_g = -1;
    for (int i = 0; i < N; i++) begin
      if (req_rdy[i]) last_g = i;
    end
    last_cnt = int'(inflight_cnt);
    last_rsp = rsp_vld;
    if (r) begin
      sb.delete();
      m_rr = 0;
    end else begin
      if (hs) void'(sb.pop_front());
      if (evi && tree_rdy_out) begin
        sb.push_back('{g, vsum(req_list[g])});
`ifdef REDUCE_ARB_PRIO_EN
        if (g != 0) m_rr = (g + 1) % N;
`else
        m_rr = (g + 1) % N;
`endif
      end
    end
  endtask

  initial begin
    int gs [6];
    repeat (2) @(negedge clk);
    step('1, '1, 1'b1);

    // Alternating grants between requesters 0 and 1.
    fill = 1;
    for (int i = 0; i < 4; i++) begin
      step(3'b011, '1, 1'b0);
      gs[i] = last_g;
    end
    chk("alt_g0", gs[0], 0);
    chk("alt_g1", gs[1], 1);
    chk("alt_g2", gs[2], 0);
    chk("alt_g3", gs[3], 1);
    fill = 2;
    repeat (2) step(3'b011, '1, 1'b0);
    repeat (8) step('0, '1, 1'b0);

    // Head tag blocked: FIFO fills to TAG_DEPTH and issue stops.
    fill = 0;
    step(3'b010, 3'b101, 1'b0);
    repeat (10) step(3'b001, 3'b101, 1'b0);
    chk("full_cnt", last_cnt, TD);
    chk("full_g", last_g, -1);
    step(3'b001, 3'b010, 1'b0);
    chk("pop_cnt", last_cnt, 8);
    chk("pop_noissue", last_g, -1);
    step(3'b001, 3'b010, 1'b0);
    chk("refill_cnt", last_cnt, 7);
    chk("refill_g", last_g, 0);
    step('0, 3'b010, 1'b0);
    chk("back_cnt", last_cnt, 8);
    repeat (14) step('0, '1, 1'b0);

    // Reset with three tags in flight.
    repeat (3) step(3'b001, '0, 1'b0);
    step('1, '1, 1'b1);
    step('0, '1, 1'b0);
    chk("rst_cnt", last_cnt, 0);
    chk("rst_rsp", last_rsp, 0);
    step('1, '1, 1'b0);
    chk("rst_first", last_g, 0);

    // Lone requester 2 from rr_ptr=0, then wrap back to 0.
    step('0, '1, 1'b1);
    step(3'b100, '1, 1'b0);
    chk("lone_g2", last_g, 2);
    step('1, '1, 1'b0);
    chk("wrap_g0", last_g, 0);

    for (int i = 0; i < 3; i++) begin
      step('1, '1, 1'b0);
      gs[i] = last_g;
    end
    for (int i = 3; i < 6; i++) begin
      step(3'b110, '1, 1'b0);
      gs[i] = last_g;
    end
`ifdef REDUCE_ARB_PRIO_EN
    chk("prio_a", gs[0], 0);
    chk("prio_b", gs[1], 0);
    chk("prio_c", gs[2], 0);
`else
    chk("rr_a", gs[0], 1);
    chk("rr_b", gs[1], 2);
    chk("rr_c", gs[2], 0);
`endif
    chk("rest_a", gs[3], 1);
    chk("rest_b", gs[4], 2);
    chk("rest_c", gs[5], 1);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 120; i++) begin
      fill = $urandom_range(0, 3) == 0 ? 1 : 0;
      step(N'($urandom_range(0, 7)),
           N'($urandom_range(0, 7) | $urandom_range(0, 7)),
           ($urandom_range(0, 59) == 0));
    end
    repeat (20) step('0, '1, 1'b0);
    chk("drained", last_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
